// File: rtl/mger_seg_mult_pipe.sv
// ---------------------------------------------------------------------------
// mger_seg_mult_pipe
//
// Pipelined segmented unsigned multiplier for the MGER approximate-multiplier
// datapath. Each W-bit operand is split into high/low K-bit halves (K = W/2).
// Stage 1 registers the four KxK partial products plus mode and a "low half
// is zero" flag. Stage 2 registers the recombined 2W-bit result: either the
// exact product, or the MGER approximation which drops the low x low block
// and adds a fixed compensation of 2^(2K-2) unless a low half is zero.
//
// Handshake: a beat transfers on any rising edge where valid & ready are both
// high. A producer holding valid may change data only after the transfer.
// in_ready depends combinationally on out_ready (no skid buffer).
//
// Parameters:
//   W            operand width, even and >= 4
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operand beat valid
//   in_ready     block can accept a beat this cycle
//   in_a, in_b   unsigned operands (W bits)
//   in_mode      0 = exact, 1 = approximate
//   out_valid    result beat valid
//   out_ready    downstream accepts the result
//   out_product  result (2W bits)
//   out_mode     mode that produced out_product
// ---------------------------------------------------------------------------
module mger_seg_mult_pipe #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic             out_mode
);

  localparam int K  = W / 2;
  localparam int PW = 2 * W;

  // Operand halves
  logic [K-1:0] a_h, a_l, b_h, b_l;
  assign a_h = in_a[W-1:K];
  assign a_l = in_a[K-1:0];
  assign b_h = in_b[W-1:K];
  assign b_l = in_b[K-1:0];

  // Stage 1 state
  logic         s1_valid;
  logic         s1_mode;
  logic         s1_lz;
  logic [W-1:0] s1_hh, s1_hl, s1_lh, s1_ll;

  // Stage 2 state (drives the outputs directly)
  logic          s2_valid;
  logic [PW-1:0] s2_product;
  logic          s2_mode;

  // Flow control
  logic s2_advance;
  logic s1_advance;
  logic in_accept;

  assign s2_advance = s2_valid & out_ready;
  assign s1_advance = s1_valid & (!s2_valid | s2_advance);
  assign in_ready   = !s1_valid | s1_advance;
  assign in_accept  = in_valid & in_ready;

  // KxK partial products, each fits in 2K = W bits
  logic [W-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  assign pp_hh = W'(a_h) * W'(b_h);
  assign pp_hl = W'(a_h) * W'(b_l);
  assign pp_lh = W'(a_l) * W'(b_h);
  assign pp_ll = W'(a_l) * W'(b_l);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_lz    <= 1'b0;
      s1_hh    <= '0;
      s1_hl    <= '0;
      s1_lh    <= '0;
      s1_ll    <= '0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      s1_lz    <= (a_l == '0) | (b_l == '0);
      s1_hh    <= pp_hh;
      s1_hl    <= pp_hl;
      s1_lh    <= pp_lh;
      s1_ll    <= pp_ll;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Recombination at full 2W width. HH << 2K is HH placed in the top W bits.
  logic [PW-1:0] sum_hh, sum_mid, sum_low, sum_total;
  assign sum_hh  = {s1_hh, {W{1'b0}}};
  assign sum_mid = (PW'(s1_hl) + PW'(s1_lh)) << K;

  // Approximate mode replaces LL with a constant midpoint estimate, except
  // when a low half is zero, where LL is known to be exactly zero.
  always_comb begin
    sum_low = PW'(s1_ll);
    if (s1_mode) begin
      sum_low = s1_lz ? '0 : (PW'(1) << (2 * K - 2));
    end
  end

  assign sum_total = sum_hh + sum_mid + sum_low;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_product <= '0;
      s2_mode    <= 1'b0;
    end else if (s1_advance) begin
      s2_valid   <= 1'b1;
      s2_product <= sum_total;
      s2_mode    <= s1_mode;
    end else if (s2_advance) begin
      // Data is left in place; only the valid bit drops.
      s2_valid <= 1'b0;
    end
  end

  assign out_valid   = s2_valid;
  assign out_product = s2_product;
  assign out_mode    = s2_mode;

endmodule

// File: tb/tb_mger_seg_mult_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for mger_seg_mult_pipe. Directed checks on a W=8 instance, then
// random valid/ready regressions on W=4, 8 and 16 instances in parallel,
// each scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mger_seg_mult_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic rand_go = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model straight from the arithmetic definition: the exact
  // product, or the exact product with LL removed and the compensation added.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic m, input int w);
    longint unsigned al, bl, p, half;
    half = 64'd1 << (w / 2);
    al = 64'(a) % half;
    bl = 64'(b) % half;
    p  = 64'(a) * 64'(b);
    if (m) p = p - al * bl + ((al == 0 || bl == 0) ? 64'd0 : (64'd1 << (w - 2)));
    return p;
  endfunction

  // ---------------- directed DUT (W=8) ----------------
  logic        in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b0, out_mode;
  logic [15:0] out_product;

  mger_seg_mult_pipe #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_mode(out_mode)
  );

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge. Sends one beat with out_ready high and
  // checks the two-register latency and the result.
  task automatic drive_one(input logic [7:0] a, input logic [7:0] b, input logic m,
                           input logic [15:0] exp, input string tag);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;                 // accepted on this edge
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_product"}, 64'(out_product), 64'(exp));
    check({tag, "_mode"}, 64'(out_mode), 64'(m));
    @(posedge clk); #1;                 // consumed
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_product"}, 64'(out_product), 64'd0);
    check({tag, "_out_mode"}, 64'(out_mode), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Directed vectors: a, b, mode, expected product
  typedef struct { logic [7:0] a; logic [7:0] b; logic m; logic [15:0] p; } vec_t;
  vec_t vecs[8] = '{
    '{8'hB7, 8'h5C, 1'b0, 16'h41C4},
    '{8'hB7, 8'h5C, 1'b1, 16'h41B0},
    '{8'hF0, 8'hFF, 1'b1, 16'hEF10},
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'hFF, 8'hFF, 1'b1, 16'hFD60},
    '{8'h00, 8'hA5, 1'b1, 16'h0000},
    '{8'h3C, 8'h00, 1'b0, 16'h0000},
    '{8'h00, 8'h00, 1'b1, 16'h0000}
  };

  task automatic backpressure_test();
    logic [7:0] bp_a[6], bp_b[6];
    int idx, got;
    logic acc;
    for (int j = 0; j < 6; j++) begin
      bp_a[j] = 8'($urandom());
      bp_b[j] = 8'($urandom());
    end
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        in_a = bp_a[idx]; in_b = bp_b[idx]; in_mode = idx[0];
      end
      @(negedge clk);
      if (cyc == 4) begin
        check("bp_accepts_before_stall", 64'(idx), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      if (cyc == 5) check("bp_in_ready_release", 64'(in_ready), 64'd1);
      if (out_valid && !out_ready) begin
        check("bp_hold_product", 64'(out_product), ref_prod(32'(bp_a[0]), 32'(bp_b[0]), 1'b0, 8));
        check("bp_hold_mode", 64'(out_mode), 64'd0);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("bp_out_product", 64'(out_product),
              ref_prod(32'(bp_a[got]), 32'(bp_b[got]), got[0], 8));
        check("bp_out_mode", 64'(out_mode), 64'(got[0]));
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_out_count", 64'(got), 64'd6);
  endtask

  task automatic reset_full_test();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h9D; in_b = 8'h6E; in_mode = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h44; in_b = 8'h21; in_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_full_out_valid", 64'(out_valid), 64'd1);
    check("rst_pre_full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("rst_mid");
    @(posedge clk); #1;
    drive_one(8'h5A, 8'h3B, 1'b0, 16'(ref_prod(32'h5A, 32'h3B, 1'b0, 8)), "post_rst");
  endtask

  // ---------------- random regression, W in {4, 8, 16} ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int RW = (g == 0) ? 4 : (g == 1) ? 8 : 16;

    logic            r_in_valid = 1'b0, r_in_ready, r_in_mode = 1'b0;
    logic [RW-1:0]   r_a = '0, r_b = '0;
    logic            r_out_valid, r_out_ready = 1'b0, r_out_mode;
    logic [2*RW-1:0] r_prod;
    logic [2*RW:0]   exp_q[$];
    logic            done = 1'b0;

    mger_seg_mult_pipe #(.W(RW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(r_in_valid), .in_ready(r_in_ready),
      .in_a(r_a), .in_b(r_b), .in_mode(r_in_mode),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .out_product(r_prod), .out_mode(r_out_mode)
    );

    initial begin
      logic acc, held;
      logic [2*RW:0] held_val, e;
      int sent, recv;
      acc = 1'b1; held = 1'b0; held_val = '0; sent = 0; recv = 0;
      wait (rand_go);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (cyc >= 1200) begin
          r_in_valid  = 1'b0;
          r_out_ready = 1'b1;
        end else begin
          if (!r_in_valid || acc) begin
            r_in_valid = ($urandom_range(0, 3) != 0);
            r_a = RW'($urandom());
            r_b = RW'($urandom());
            // Bias towards zero low halves to exercise the no-compensation case
            if ($urandom_range(0, 5) == 0) r_a[RW/2-1:0] = '0;
            if ($urandom_range(0, 5) == 0) r_b[RW/2-1:0] = '0;
            r_in_mode = 1'($urandom_range(0, 1));
          end
          r_out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        acc = r_in_valid && r_in_ready;
        if (acc) begin
          exp_q.push_back({r_in_mode,
                           (2*RW)'(ref_prod(32'(r_a), 32'(r_b), r_in_mode, RW))});
          sent++;
        end
        if (held) begin
          check($sformatf("w%0d_hold_valid", RW), 64'(r_out_valid), 64'd1);
          check($sformatf("w%0d_hold_data", RW), 64'({r_out_mode, r_prod}), 64'(held_val));
        end
        if (r_out_valid && r_out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("w%0d_unexpected_out", RW), 64'({r_out_mode, r_prod}), 64'hDEAD_BEEF_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("w%0d_product", RW), 64'(r_prod), 64'(e[2*RW-1:0]));
            check($sformatf("w%0d_mode", RW), 64'(r_out_mode), 64'(e[2*RW]));
          end
          recv++;
        end
        held = r_out_valid && !r_out_ready;
        held_val = {r_out_mode, r_prod};
        @(posedge clk); #1;
      end
      check($sformatf("w%0d_queue_empty", RW), 64'(exp_q.size()), 64'd0);
      check($sformatf("w%0d_sent_vs_recv", RW), 64'(recv), 64'(sent));
      done = 1'b1;
    end
  end

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state("reset");
    @(posedge clk); #1;

    foreach (vecs[i])
      drive_one(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].p, $sformatf("vec%0d", i));

    // Back-to-back beats with out_ready high: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 8'(8'h11 * (i + 3)); in_b = 8'(8'h29 + i * 7); in_mode = i[0];
      @(negedge clk);
      check("tput_in_ready", 64'(in_ready), 64'd1);
      if (i >= 2) begin
        check("tput_out_valid", 64'(out_valid), 64'd1);
        check("tput_product", 64'(out_product),
              ref_prod(32'(8'h11 * (i + 1)), 32'(8'h29 + (i - 2) * 7), i[0], 8));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    backpressure_test();
    repeat (3) @(posedge clk);
    #1;
    reset_full_test();

    rand_go = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && waited < 5000) begin
        @(posedge clk);
        waited++;
      end
      check("rand_completed", 64'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
